// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state type and default sizes for the data memory arbiter
// Contents: arb_state_t FSM encoding, default ADDR_W/DATA_W/STARVE_LIM, counter width.
package arb_pkg;

  localparam int ADDR_W_DEF     = 10;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_LIM_DEF = 4;

  // Width of the starvation counter; limits up to 15 fit.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_RD   = 2'd1,
    EXT_RD   = 2'd2,
    EXT_WACK = 2'd3
  } arb_state_t;

endpackage

// File: rtl/starve_counter.sv
// rtl/starve_counter.sv - saturating count of arbitrations lost by the external requester
// Ports: clk, rst (async active-low), inc (ext lost a round), clr (ext granted or idle),
//        lim (saturation value), sat (count has reached lim).
module starve_counter
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic [CNT_W-1:0] lim,
  output logic             sat
);

  logic [CNT_W-1:0] cnt;

  // clr has priority so a grant in the same cycle never leaves a stale count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < lim)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sat = (cnt == lim);

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - single-port data RAM shared between the CPU memory stage and an external port
// Ports: clk, rst (async active-low);
//        cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_rdata/cpu_stall out;
//        ext_req/ext_we/ext_addr/ext_wdata in, ext_gnt/ext_done/ext_rdata out;
//        mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in (valid one cycle after issue).
module data_mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_done,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic              in_idle;
  logic              ext_win;
  logic              cpu_win;
  logic              starve_sat;
  logic              cnt_inc;
  logic              cnt_clr;
  logic [DATA_W-1:0] ext_rdata_q;

  assign in_idle = (state == IDLE);

  // Ext only loses to the CPU while it is actually requesting; a quiet ext
  // port resets its fairness history.
  assign cnt_inc = cpu_win && ext_req;
  assign cnt_clr = ext_win || (in_idle && !ext_req);

  starve_counter u_starve (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .clr (cnt_clr),
    .lim (LIM),
    .sat (starve_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_rdata_q <= '0;
    end else if (state == EXT_RD) begin
      ext_rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    ext_win   = 1'b0;
    cpu_win   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    ext_gnt   = 1'b0;
    ext_done  = 1'b0;
    ext_rdata = ext_rdata_q;

    case (state)
      IDLE: begin
        ext_win = ext_req && (starve_sat || !cpu_req);
        cpu_win = cpu_req && !ext_win;
        if (ext_win) begin
          mem_en    = 1'b1;
          mem_we    = ext_we;
          mem_addr  = ext_addr;
          mem_wdata = ext_wdata;
          ext_gnt   = 1'b1;
          cpu_stall = cpu_req;
          state_nxt = ext_we ? EXT_WACK : EXT_RD;
        end else if (cpu_win) begin
          mem_en    = 1'b1;
          mem_we    = cpu_we;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          // Writes retire in the issue cycle; reads wait for the RAM.
          if (!cpu_we) begin
            cpu_stall = 1'b1;
            state_nxt = CPU_RD;
          end
        end
      end
      CPU_RD: begin
        cpu_rdata = mem_rdata;
        state_nxt = IDLE;
      end
      EXT_RD: begin
        // Bypass so the read data is visible in the same cycle as ext_done.
        ext_done  = 1'b1;
        ext_rdata = mem_rdata;
        cpu_stall = cpu_req;
        state_nxt = IDLE;
      end
      EXT_WACK: begin
        ext_done  = 1'b1;
        cpu_stall = cpu_req;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Outputs driven straight from inputs must also go quiet the moment reset asserts.
    if (!rst) begin
      ext_win   = 1'b0;
      cpu_win   = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      cpu_stall = 1'b0;
      cpu_rdata = '0;
      ext_gnt   = 1'b0;
      ext_done  = 1'b0;
      ext_rdata = '0;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata, ext_rdata;
  logic          ext_gnt, ext_done;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_done(ext_done), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM the arbiter drives.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction-level view with outstanding-access flags and
  // a mirror of memory contents; read data is the memory value at issue time.
  logic [DW-1:0] mmem [0:(1<<AW)-1];
  int            m_starve;
  bit            m_cpu_pend, m_ext_rd_pend, m_ext_wr_pend, m_gnt_prev;
  logic [DW-1:0] m_cpu_val, m_ext_val, m_ext_last;
  bit            m_ext_win, m_cpu_win;

  logic          e_en, e_we, e_stall, e_gnt, e_done;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_cpu_rdata, e_ext_rdata;

  task automatic compute();
    e_en = 0; e_we = 0; e_addr = '0; e_wd = '0; e_stall = 0; e_gnt = 0; e_done = 0;
    e_cpu_rdata = '0; e_ext_rdata = m_ext_last;
    m_ext_win = 0; m_cpu_win = 0;
    if (!rst) begin
      e_ext_rdata = '0;
    end else if (m_cpu_pend) begin
      e_cpu_rdata = m_cpu_val;
    end else if (m_ext_rd_pend || m_ext_wr_pend) begin
      e_done  = 1;
      e_stall = cpu_req;
      if (m_ext_rd_pend) e_ext_rdata = m_ext_val;
    end else begin
      m_ext_win = ext_req && (m_starve == LIM || !cpu_req);
      m_cpu_win = cpu_req && !m_ext_win;
      if (m_ext_win) begin
        e_en = 1; e_we = ext_we; e_addr = ext_addr; e_wd = ext_wdata;
        e_gnt = 1; e_stall = cpu_req;
      end else if (m_cpu_win) begin
        e_en = 1; e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata;
        e_stall = !cpu_we;
      end
    end
  endtask

  task automatic model_update();
    bit busy;
    if (!rst) begin
      m_starve = 0; m_cpu_pend = 0; m_ext_rd_pend = 0; m_ext_wr_pend = 0;
      m_ext_last = '0; m_gnt_prev = 0;
      return;
    end
    busy = m_cpu_pend || m_ext_rd_pend || m_ext_wr_pend;
    if (m_ext_rd_pend) m_ext_last = m_ext_val;
    m_cpu_pend = 0; m_ext_rd_pend = 0; m_ext_wr_pend = 0;
    m_gnt_prev = m_ext_win;
    if (!busy) begin
      if (m_ext_win) begin
        m_starve = 0;
        if (ext_we) begin mmem[ext_addr] = ext_wdata; m_ext_wr_pend = 1; end
        else begin m_ext_val = mmem[ext_addr]; m_ext_rd_pend = 1; end
      end else if (m_cpu_win) begin
        m_starve = ext_req ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
        if (cpu_we) mmem[cpu_addr] = cpu_wdata;
        else begin m_cpu_val = mmem[cpu_addr]; m_cpu_pend = 1; end
      end else begin
        m_starve = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("mem_en", {31'b0, mem_en}, {31'b0, e_en});
    chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
    chk("mem_addr", {22'b0, mem_addr}, {22'b0, e_addr});
    chk("mem_wdata", mem_wdata, e_wd);
    chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, e_stall});
    chk("cpu_rdata", cpu_rdata, e_cpu_rdata);
    chk("ext_gnt", {31'b0, ext_gnt}, {31'b0, e_gnt});
    chk("ext_done", {31'b0, ext_done}, {31'b0, e_done});
    chk("ext_rdata", ext_rdata, e_ext_rdata);
  endtask

  // Called at posedge+1; samples at posedge+3.
  task automatic sample();
    #2;
    compute();
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_in(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input logic er, input logic ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(0, 0, '0, '0, 0, 0, '0, '0);
      sample();
      advance();
    end
  endtask

  typedef struct {
    logic cr, cw; logic [AW-1:0] ca; logic [DW-1:0] cd;
    logic er, ew; logic [AW-1:0] ea; logic [DW-1:0] ed;
    logic x_en, x_we; logic [AW-1:0] x_addr; logic [DW-1:0] x_wd;
    logic x_stall, x_gnt;
  } vec_t;

  vec_t tbl [7];

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]  = 32'h100 + 32'(i * 7);
      mmem[i] = 32'h100 + 32'(i * 7);
    end
    ram[3] = 32'h1234; mmem[3] = 32'h1234;
    mem_rdata = '0;
    m_starve = 0; m_cpu_pend = 0; m_ext_rd_pend = 0; m_ext_wr_pend = 0; m_gnt_prev = 0;
    m_cpu_val = '0; m_ext_val = '0; m_ext_last = '0;

    //          cr cw ca  cd     er ew ea  ed      en we addr wd     stall gnt
    tbl[0] = '{0, 0, 0, 0,       0, 0, 0, 0,       0, 0, 0, 0,       0, 0};
    tbl[1] = '{1, 1, 5, 'hA5,    0, 0, 0, 0,       1, 1, 5, 'hA5,    0, 0};
    tbl[2] = '{1, 0, 5, 'h77,    0, 0, 0, 0,       1, 0, 5, 'h77,    1, 0};
    tbl[3] = '{0, 0, 0, 0,       1, 0, 3, 'h9,     1, 0, 3, 'h9,     0, 1};
    tbl[4] = '{0, 0, 0, 0,       1, 1, 7, 'h55,    1, 1, 7, 'h55,    0, 1};
    tbl[5] = '{1, 1, 9, 'h99,    1, 0, 3, 'h11,    1, 1, 9, 'h99,    0, 0};
    tbl[6] = '{1, 0, 2, 'h22,    1, 1, 4, 'h44,    1, 0, 2, 'h22,    1, 0};

    // Reset with both requesters active: everything must be quiet.
    rst = 0;
    set_in(1, 1, 10'd5, 32'hDEAD, 1, 0, 10'd3, 32'hBEEF);
    #1;
    sample();
    chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_gnt", {31'b0, ext_gnt}, 32'd0);
    advance();
    rst = 1;
    idle_cycles(2);

    // Single-cycle arbitration vectors, each from a clean IDLE.
    for (int v = 0; v < 7; v++) begin
      set_in(tbl[v].cr, tbl[v].cw, tbl[v].ca, tbl[v].cd, tbl[v].er, tbl[v].ew, tbl[v].ea, tbl[v].ed);
      sample();
      chk($sformatf("vec%0d_en", v), {31'b0, mem_en}, {31'b0, tbl[v].x_en});
      chk($sformatf("vec%0d_we", v), {31'b0, mem_we}, {31'b0, tbl[v].x_we});
      chk($sformatf("vec%0d_addr", v), {22'b0, mem_addr}, {22'b0, tbl[v].x_addr});
      chk($sformatf("vec%0d_wd", v), mem_wdata, tbl[v].x_wd);
      chk($sformatf("vec%0d_stall", v), {31'b0, cpu_stall}, {31'b0, tbl[v].x_stall});
      chk($sformatf("vec%0d_gnt", v), {31'b0, ext_gnt}, {31'b0, tbl[v].x_gnt});
      advance();
      idle_cycles(2);
    end

    // CPU write then read of address 5.
    set_in(1, 1, 10'd5, 32'hA5, 0, 0, '0, '0);
    sample();
    chk("cw_stall", {31'b0, cpu_stall}, 32'd0);
    advance();
    set_in(1, 0, 10'd5, '0, 0, 0, '0, '0);
    sample();
    chk("cr_c0_stall", {31'b0, cpu_stall}, 32'd1);
    advance();
    sample();
    chk("cr_c1_rdata", cpu_rdata, 32'hA5);
    chk("cr_c1_stall", {31'b0, cpu_stall}, 32'd0);
    advance();
    idle_cycles(1);
    chk("cr_idle_rdata", cpu_rdata, 32'd0);

    // Ext read of address 3.
    set_in(0, 0, '0, '0, 1, 0, 10'd3, '0);
    sample();
    chk("er_c0_gnt", {31'b0, ext_gnt}, 32'd1);
    advance();
    set_in(0, 0, '0, '0, 0, 0, '0, '0);
    sample();
    chk("er_c1_done", {31'b0, ext_done}, 32'd1);
    chk("er_c1_rdata", ext_rdata, 32'h1234);
    advance();
    sample();
    chk("er_c2_done", {31'b0, ext_done}, 32'd0);
    chk("er_c2_hold", ext_rdata, 32'h1234);
    advance();

    // Starvation: ext loses LIM times, wins on the next IDLE cycle.
    for (int k = 0; k < LIM; k++) begin
      set_in(1, 1, 10'(k + 40), 32'(k), 1, 1, 10'd20, 32'hBEEF);
      sample();
      chk($sformatf("starve%0d_gnt", k), {31'b0, ext_gnt}, 32'd0);
      chk($sformatf("starve%0d_stall", k), {31'b0, cpu_stall}, 32'd0);
      advance();
    end
    set_in(1, 1, 10'd50, 32'h5, 1, 1, 10'd20, 32'hBEEF);
    sample();
    chk("starve_win_gnt", {31'b0, ext_gnt}, 32'd1);
    chk("starve_win_stall", {31'b0, cpu_stall}, 32'd1);
    chk("starve_win_addr", {22'b0, mem_addr}, 32'd20);
    advance();
    set_in(1, 1, 10'd50, 32'h5, 0, 0, '0, '0);
    sample();
    chk("starve_wack_done", {31'b0, ext_done}, 32'd1);
    chk("starve_wack_stall", {31'b0, cpu_stall}, 32'd1);
    advance();
    sample();
    chk("starve_after_stall", {31'b0, cpu_stall}, 32'd0);
    advance();
    idle_cycles(1);

    // Reset in the middle of EXT_RD discards the read.
    set_in(0, 0, '0, '0, 1, 0, 10'd3, '0);
    sample();
    chk("rrd_gnt", {31'b0, ext_gnt}, 32'd1);
    advance();
    set_in(1, 0, 10'd8, '0, 0, 0, '0, '0);
    sample();
    chk("rrd_done_pre", {31'b0, ext_done}, 32'd1);
    rst = 0;
    #1;
    chk("rrd_done", {31'b0, ext_done}, 32'd0);
    chk("rrd_rdata", ext_rdata, 32'd0);
    chk("rrd_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rrd_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rrd_cpu_rdata", cpu_rdata, 32'd0);
    advance();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, '0, '0, 0, 0, '0, '0);
      sample();
      chk($sformatf("rrd_post%0d_done", i), {31'b0, ext_done}, 32'd0);
      advance();
    end

    // Randomized traffic against the model; ext holds operands until granted.
    for (int c = 0; c < 3000; c++) begin
      cpu_req   = ($urandom_range(0, 2) != 0);
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_addr  = 10'($urandom_range(0, 15));
      cpu_wdata = $urandom;
      if (!ext_req || m_gnt_prev || ($urandom_range(0, 19) == 0)) begin
        ext_req   = ($urandom_range(0, 2) == 0);
        ext_we    = $urandom_range(0, 1) == 1;
        ext_addr  = 10'($urandom_range(0, 15));
        ext_wdata = $urandom;
      end
      rst = ($urandom_range(0, 299) != 0);
      sample();
      advance();
    end
    rst = 1;
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 10, data-memory word-address width.
- DATA_W, 32, data width.
- STARVE_LIM, 4, number of consecutive lost arbitrations after which ext wins; legal range 1..15.

REQ-002 Ports, one per line: name, direction, width, meaning. The block has one clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU memory-stage access request.
- cpu_we  in  1  CPU write (1) or read (0).
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_stall  out  1  CPU pipeline must hold.
- ext_req  in  1  external (loader/debug) request.
- ext_we  in  1  external write (1) or read (0).
- ext_addr  in  ADDR_W  external address.
- ext_wdata  in  DATA_W  external write data.
- ext_gnt  out  1  external access issued this cycle.
- ext_done  out  1  external access complete; ext_rdata is valid for reads.
- ext_rdata  out  DATA_W  external read data.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  synchronous RAM read data, valid 1 cycle after the issue cycle.

Function
REQ-003 The FSM SHALL have states IDLE, CPU_RD, EXT_RD and EXT_WACK.
REQ-004 Arbitration SHALL occur only in IDLE. The CPU wins, except that ext wins when starve_cnt == STARVE_LIM.
REQ-005 The winner's access SHALL be issued combinationally in the same cycle: mem_en=1, and mem_we/mem_addr/mem_wdata are taken from the winner.
REQ-006 A CPU write SHALL complete in the issue cycle: cpu_stall=0 and the FSM stays in IDLE.
REQ-007 A CPU read SHALL proceed as follows:
- issue cycle: cpu_stall=1, next state CPU_RD;
- CPU_RD: cpu_rdata=mem_rdata, cpu_stall=0, next state IDLE.
REQ-008 An ext grant SHALL assert ext_gnt=1 in the issue cycle, with next state EXT_RD for a read or EXT_WACK for a write. In either state ext_done=1 for one cycle, then the FSM returns to IDLE.
REQ-009 In EXT_RD, ext_rdata SHALL be registered from mem_rdata and held until the next ext read completes.
REQ-010 cpu_stall SHALL be 1 whenever cpu_req=1 and the CPU does not win IDLE arbitration. This includes cycles in EXT_RD and EXT_WACK.
REQ-011 When the FSM is not in CPU_RD, cpu_rdata SHALL be 0.
REQ-012 starve_cnt (4 bits) SHALL update each clock edge as follows:
- increments when in IDLE, ext_req=1 and the CPU wins;
- holds during non-IDLE states;
- clears when ext is granted, or when ext_req=0 in IDLE;
- saturates at STARVE_LIM.
REQ-013 The ext requester SHALL hold ext_req and its operands stable until ext_gnt. Deasserting ext_req before the grant withdraws the request with no memory access.
REQ-014 When both requests are idle, all mem_* outputs SHALL be 0.
REQ-015 Requests arriving in a non-IDLE state SHALL be arbitrated in the next IDLE cycle. No request is ever dropped.

Reset
REQ-016 Reset (rst=0) SHALL asynchronously force the following:
- state=IDLE and starve_cnt=0;
- ext_rdata=0, ext_done=0, ext_gnt=0;
- cpu_rdata=0;
- all mem_* outputs = 0.
While rst=0, cpu_stall SHALL be 0.
REQ-017 Reset during CPU_RD or EXT_RD SHALL discard the pending read. No ext_done is produced for it after reset release.

Structure
REQ-018 Package arb_pkg SHALL hold the following:
- the state enum arb_state_t;
- the default ADDR_W/DATA_W/STARVE_LIM constants.
REQ-019 The starvation counter SHALL be a sub-module named starve_counter, with ports clk, rst, inc, clr, lim and sat.

Verification
REQ-020 CPU write, ext idle: cpu_req=1, we=1, addr=5, wdata=0xA5 -> same cycle mem_en=1, mem_we=1, mem_addr=5, cpu_stall=0.
REQ-021 CPU read of addr 5 holding 0xA5 -> cycle0 cpu_stall=1; cycle1 cpu_rdata=0xA5, cpu_stall=0.
REQ-022 Ext read of addr 3 (holding 0x1234) with CPU idle -> cycle0 ext_gnt=1; cycle1 ext_done=1, ext_rdata=0x1234.
REQ-023 Continuous CPU writes plus ext_req held, STARVE_LIM=4 -> ext granted on the 5th IDLE cycle. In that cycle cpu_stall=1, and cpu_stall=1 also in the following EXT_WACK/EXT_RD cycle.
REQ-024 Simultaneous cpu_req and ext_req, starve_cnt=0 -> CPU wins; ext_gnt=0; starve_cnt=1 next cycle.
REQ-025 rst=0 asserted in EXT_RD -> immediately all outputs 0, state IDLE; after release no ext_done until a new ext_gnt.
